gon_drain_ctrl: RTL and testbench
=================================

Name: gon_drain_ctrl

Overview:
- Sequencer for the gather-output network (GON) that moves PE-array results (psums) back to the GLB.
- Two jobs: (1) after reset or on request, scans row-major default IDs into the GON X/Y ID chains; (2) on a drain command, sweeps tag_Y/tag_X over a programmable active PE window, holding each tag until a programmable number of GON_valid&&GON_ready transfers has completed.
- Sits between the top-level controller and the GON; observes the GON<->GLB handshake but does not carry data.

Parameters:
- NUMS_PE_ROW, 6, PE array rows (= number of Y IDs).
- NUMS_PE_COL, 8, PE array columns.
- XID_BITS, 4, X tag width; requires NUMS_PE_COL < 2**XID_BITS.
- YID_BITS, 3, Y tag width; requires NUMS_PE_ROW < 2**YID_BITS.
- WCNT_BITS, 8, width of the words-per-PE counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start_cfg  in  1  one-cycle pulse: begin ID scan
- start_drain  in  1  one-cycle pulse: begin drain
- cfg_rows  in  YID_BITS  active rows minus 1 (0..NUMS_PE_ROW-1)
- cfg_cols  in  XID_BITS  active cols minus 1 (0..NUMS_PE_COL-1)
- words_per_pe  in  WCNT_BITS  transfers per PE minus 1
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when a scan or drain completes
- set_XID  out  1  X ID chain shift enable
- XID_scan_in  out  XID_BITS  X ID chain input
- set_YID  out  1  Y ID chain shift enable
- YID_scan_in  out  YID_BITS  Y ID chain input
- tag_X  out  XID_BITS  X tag to GON
- tag_Y  out  YID_BITS  Y tag to GON
- GON_valid  in  1  GON->GLB valid (monitored)
- GON_ready  in  1  GLB->GON ready (monitored)

Behaviour:
- Clock and reset: all state updates on posedge clk. rst (synchronous, active-high) forces IDLE, clears counters, and sets done=0, busy=0, set_XID=0, set_YID=0, scan data=0, tag_X=all-ones, tag_Y=all-ones. Reset mid-scan or mid-drain aborts immediately with no done pulse.
- Reserved tag: the all-ones tag never matches a PE. It is driven on tag_X/tag_Y in every state except DRAIN.
- FSM states: IDLE, SCAN_X, SCAN_Y, DRAIN, DONE.
- IDLE transitions:
  - start_cfg -> SCAN_X.
  - Otherwise start_drain -> DRAIN, latching cfg_rows, cfg_cols and words_per_pe; y=0, x=0, wcnt=0.
  - start_cfg wins if both are asserted in the same cycle.
  - Starts received while busy are ignored (not queued).
- SCAN_X: NUMS_PE_ROW*NUMS_PE_COL cycles with set_XID=1. Cycle k (k=0..N-1) drives XID_scan_in = (N-1-k) mod NUMS_PE_COL, so the value for the farthest chain position is emitted first. After the last cycle -> SCAN_Y.
- SCAN_Y: NUMS_PE_ROW cycles with set_YID=1. Cycle k drives YID_scan_in = NUMS_PE_ROW-1-k. After the last cycle -> DONE.
- Outside their scan states, set_XID and set_YID are 0 and the scan data outputs are 0.
- DRAIN tag order: tag_Y=y, tag_X=x are registered outputs; the first tag appears the cycle after the start pulse.
- DRAIN handshake: fire = GON_valid && GON_ready. On each fire:
  - if wcnt < words_lat: wcnt++;
  - else wcnt=0 and the window advances x++; at x==cols_lat, x=0 and y++; at y==rows_lat, -> DONE.
- DRAIN tag timing: the tag changes the cycle after the final fire for a PE. Cycles with GON_valid=1 and GON_ready=0 do not advance. There is no timeout.
- DONE: done=1 for exactly one cycle, then -> IDLE. Tags are all-ones from the DONE cycle onward.
- Counter widths: x is XID_BITS wide, y is YID_BITS wide, wcnt is WCNT_BITS wide. Comparisons are exact equality against the latched limits, so there is no wrap-around.
- Out-of-range configuration: if cfg_cols >= NUMS_PE_COL or cfg_rows >= NUMS_PE_ROW, the value is clamped to the array maximum when latched.
- Transfer count: a drain completes after exactly (rows+1)*(cols+1)*(words+1) fires.

Decomposition:
- Shared package gon_ctrl_pkg:
  - state enum type gon_ctrl_state_t;
  - localparams N_PE = NUMS_PE_ROW*NUMS_PE_COL, TAG_X_NONE and TAG_Y_NONE (all-ones);
  - a function for the clamp.
- One natural sub-module, gon_tag_sweeper: the x/y/wcnt nested counter with fire, wrap and last outputs. The FSM and scan generator stay in the top module.

Test Plan:
- Reset then start_cfg with the default parameters -> 48 cycles of set_XID=1 with XID_scan_in sequence 7,6,...,0 repeated 6 times; then 6 cycles of set_YID=1 with values 5,4,3,2,1,0; done pulses on cycle 55; busy falls the next cycle.
- start_drain with cfg_rows=1, cfg_cols=2, words_per_pe=0 and GON_ready tied high, GON_valid=1 -> tags (Y,X) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2), one per cycle; done after 6 fires; tags return to (7,15).
- Drain with words_per_pe=3 and GON_ready toggling 1010 -> each tag is held until 4 fires have been counted; stall cycles do not advance; total fires = (rows+1)*(cols+1)*4.
- cfg_cols=12 (out of range), cfg_rows=0 -> clamped to 7; exactly 8 tags X=0..7 are issued.
- rst asserted mid-drain at tag (1,1) -> next cycle busy=0, tags all-ones, no done; a new start_drain restarts at (0,0).
- start_cfg and start_drain in the same cycle, plus start_drain while in SCAN_X -> scan runs, and the drain request is ignored (no DRAIN entry after DONE).

Source files
------------

// File: rtl/gon_ctrl_pkg.sv
// Shared types, default geometry and helpers for the GON drain/scan sequencer.
package gon_ctrl_pkg;
    localparam int NUMS_PE_ROW_DEF = 6;
    localparam int NUMS_PE_COL_DEF = 8;
    localparam int XID_BITS_DEF    = 4;
    localparam int YID_BITS_DEF    = 3;
    localparam int WCNT_BITS_DEF   = 8;

    localparam int N_PE = NUMS_PE_ROW_DEF * NUMS_PE_COL_DEF;
    localparam logic [XID_BITS_DEF-1:0] TAG_X_NONE = '1;
    localparam logic [YID_BITS_DEF-1:0] TAG_Y_NONE = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN_X,
        ST_SCAN_Y,
        ST_DRAIN,
        ST_DONE
    } gon_ctrl_state_t;

    function automatic int unsigned clamp_lim(input int unsigned v, input int unsigned max_v);
        return (v > max_v) ? max_v : v;
    endfunction
endpackage

// File: rtl/gon_tag_sweeper.sv
// Nested y/x/word counter over the latched PE window; advances one step per fire.
module gon_tag_sweeper #(
    parameter int XID_BITS  = 4,
    parameter int YID_BITS  = 3,
    parameter int WCNT_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_i,
    input  logic [YID_BITS-1:0]  rows_i,
    input  logic [XID_BITS-1:0]  cols_i,
    input  logic [WCNT_BITS-1:0] words_i,
    input  logic                 fire_i,
    output logic [XID_BITS-1:0]  x_o,
    output logic [YID_BITS-1:0]  y_o,
    output logic                 wrap_o,
    output logic                 last_o
);
    logic [YID_BITS-1:0]  rows_q, y_q, y_d;
    logic [XID_BITS-1:0]  cols_q, x_q, x_d;
    logic [WCNT_BITS-1:0] words_q, wcnt_q, wcnt_d;
    logic                 pe_done;

    assign pe_done = fire_i && (wcnt_q == words_q);
    assign wrap_o  = pe_done && (x_q == cols_q);
    assign last_o  = wrap_o && (y_q == rows_q);
    assign x_o     = x_q;
    assign y_o     = y_q;

    always_comb begin
        wcnt_d = wcnt_q;
        x_d    = x_q;
        y_d    = y_q;
        if (load_i) begin
            wcnt_d = '0;
            x_d    = '0;
            y_d    = '0;
        end else if (fire_i) begin
            if (!pe_done) begin
                wcnt_d = wcnt_q + 1'b1;
            end else begin
                wcnt_d = '0;
                if (!wrap_o) begin
                    x_d = x_q + 1'b1;
                end else begin
                    x_d = '0;
                    // Hold y on the final fire so it never steps past the window.
                    if (!last_o) y_d = y_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rows_q  <= '0;
            cols_q  <= '0;
            words_q <= '0;
            wcnt_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            if (load_i) begin
                rows_q  <= rows_i;
                cols_q  <= cols_i;
                words_q <= words_i;
            end
            wcnt_q <= wcnt_d;
            x_q    <= x_d;
            y_q    <= y_d;
        end
    end
endmodule

// File: rtl/gon_drain_ctrl.sv
// GON sequencer: scans default X/Y IDs into the chains, then sweeps drain tags
// over the configured PE window while counting GON handshakes.
module gon_drain_ctrl
    import gon_ctrl_pkg::*;
#(
    parameter int NUMS_PE_ROW = NUMS_PE_ROW_DEF,
    parameter int NUMS_PE_COL = NUMS_PE_COL_DEF,
    parameter int XID_BITS    = XID_BITS_DEF,
    parameter int YID_BITS    = YID_BITS_DEF,
    parameter int WCNT_BITS   = WCNT_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_cfg,
    input  logic                 start_drain,
    input  logic [YID_BITS-1:0]  cfg_rows,
    input  logic [XID_BITS-1:0]  cfg_cols,
    input  logic [WCNT_BITS-1:0] words_per_pe,
    output logic                 busy,
    output logic                 done,
    output logic                 set_XID,
    output logic [XID_BITS-1:0]  XID_scan_in,
    output logic                 set_YID,
    output logic [YID_BITS-1:0]  YID_scan_in,
    output logic [XID_BITS-1:0]  tag_X,
    output logic [YID_BITS-1:0]  tag_Y,
    input  logic                 GON_valid,
    input  logic                 GON_ready
);
    localparam int N      = NUMS_PE_ROW * NUMS_PE_COL;
    localparam int SCNT_W = $clog2(N + 1);

    gon_ctrl_state_t     state_q, state_d;
    logic [SCNT_W-1:0]   scnt_q, scnt_d;
    logic [XID_BITS-1:0] xs_q, xs_d;
    logic                load, fire, wrap, last;
    logic [XID_BITS-1:0] sw_x, cols_cl;
    logic [YID_BITS-1:0] sw_y, rows_cl;

    assign cols_cl = XID_BITS'(clamp_lim(int'(cfg_cols), NUMS_PE_COL - 1));
    assign rows_cl = YID_BITS'(clamp_lim(int'(cfg_rows), NUMS_PE_ROW - 1));
    assign load    = (state_q == ST_IDLE) && !start_cfg && start_drain;
    assign fire    = (state_q == ST_DRAIN) && GON_valid && GON_ready;

    gon_tag_sweeper #(
        .XID_BITS (XID_BITS),
        .YID_BITS (YID_BITS),
        .WCNT_BITS(WCNT_BITS)
    ) u_sweep (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .rows_i (rows_cl),
        .cols_i (cols_cl),
        .words_i(words_per_pe),
        .fire_i (fire),
        .x_o    (sw_x),
        .y_o    (sw_y),
        .wrap_o (wrap),
        .last_o (last)
    );

    // Outside DRAIN the reserved all-ones tag keeps every PE deselected.
    assign tag_X = (state_q == ST_DRAIN) ? sw_x : {XID_BITS{1'b1}};
    assign tag_Y = (state_q == ST_DRAIN) ? sw_y : {YID_BITS{1'b1}};

    always_comb begin
        state_d     = state_q;
        scnt_d      = scnt_q;
        xs_d        = xs_q;
        busy        = (state_q != ST_IDLE);
        done        = 1'b0;
        set_XID     = 1'b0;
        set_YID     = 1'b0;
        XID_scan_in = '0;
        YID_scan_in = '0;
        case (state_q)
            ST_IDLE: begin
                if (start_cfg) begin
                    state_d = ST_SCAN_X;
                    scnt_d  = SCNT_W'(N - 1);
                    xs_d    = XID_BITS'((N - 1) % NUMS_PE_COL);
                end else if (start_drain) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_SCAN_X: begin
                // Farthest chain position first: column index counts down, wrapping per row.
                set_XID     = 1'b1;
                XID_scan_in = xs_q;
                xs_d        = (xs_q == '0) ? XID_BITS'(NUMS_PE_COL - 1) : xs_q - 1'b1;
                if (scnt_q == '0) begin
                    state_d = ST_SCAN_Y;
                    scnt_d  = SCNT_W'(NUMS_PE_ROW - 1);
                end else begin
                    scnt_d = scnt_q - 1'b1;
                end
            end
            ST_SCAN_Y: begin
                set_YID     = 1'b1;
                YID_scan_in = YID_BITS'(scnt_q);
                if (scnt_q == '0) state_d = ST_DONE;
                else              scnt_d  = scnt_q - 1'b1;
            end
            ST_DRAIN: begin
                if (last) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            scnt_q  <= '0;
            xs_q    <= '0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            xs_q    <= xs_d;
        end
    end
endmodule

// File: tb/tb_gon_drain_ctrl.sv
// Scoreboard bench: expected scan values, drain tags and done pulses are queued
// from a loop-level model; a negedge monitor pops and compares observed events.
module tb_gon_drain_ctrl;
    localparam int ROWS = 6;
    localparam int COLS = 8;
    localparam int K_X = 0, K_Y = 1, K_T = 2, K_D = 3;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_cfg, start_drain;
    logic [2:0] cfg_rows;
    logic [3:0] cfg_cols;
    logic [7:0] words_per_pe;
    logic       busy, done, set_XID, set_YID;
    logic [3:0] XID_scan_in, tag_X;
    logic [2:0] YID_scan_in, tag_Y;
    logic       GON_valid, GON_ready;

    ev_t exp_q[$];
    int  vec = 0;
    int  mis = 0;

    gon_drain_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start_cfg   (start_cfg),
        .start_drain (start_drain),
        .cfg_rows    (cfg_rows),
        .cfg_cols    (cfg_cols),
        .words_per_pe(words_per_pe),
        .busy        (busy),
        .done        (done),
        .set_XID     (set_XID),
        .XID_scan_in (XID_scan_in),
        .set_YID     (set_YID),
        .YID_scan_in (YID_scan_in),
        .tag_X       (tag_X),
        .tag_Y       (tag_Y),
        .GON_valid   (GON_valid),
        .GON_ready   (GON_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        vec++;
        if (got != want) begin
            mis++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic got_ev(input int k, input int v);
        ev_t e;
        vec++;
        if (exp_q.size() == 0) begin
            mis++;
            $display("FAIL unexpected_event: got kind %0d val %0d, required none", k, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                mis++;
                $display("FAIL event: got kind %0d val %0d, required kind %0d val %0d",
                         k, v, e.kind, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (set_XID) got_ev(K_X, int'(XID_scan_in));
            if (set_YID) got_ev(K_Y, int'(YID_scan_in));
            if (busy && !done && GON_valid && GON_ready) got_ev(K_T, int'(tag_Y) * 16 + int'(tag_X));
            if (done) got_ev(K_D, 0);
        end
    end

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // mode 0: random valid/ready; 1: valid high, ready 1010...; 2: both high
    task automatic run_drain(input int r, input int c, input int w, input int mode);
        int er, ec, nfire, cyc;
        bit seen;
        ev_t e;
        er = imin(r, ROWS - 1);
        ec = imin(c, COLS - 1);
        for (int y = 0; y <= er; y++)
            for (int x = 0; x <= ec; x++)
                for (int k = 0; k <= w; k++) begin
                    e.kind = K_T; e.val = y * 16 + x;
                    exp_q.push_back(e);
                end
        e.kind = K_D; e.val = 0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        cfg_rows = 3'(r); cfg_cols = 4'(c); words_per_pe = 8'(w);
        start_drain = 1'b1;
        nfire = 0; seen = 1'b0; cyc = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            start_drain = 1'b0;
            case (mode)
                0: begin GON_valid = ($urandom_range(0, 3) != 0); GON_ready = 1'($urandom_range(0, 1)); end
                1: begin GON_valid = 1'b1; GON_ready = (cyc % 2 == 0); end
                default: begin GON_valid = 1'b1; GON_ready = 1'b1; end
            endcase
            cyc++;
            @(negedge clk);
            if (done) begin seen = 1'b1; break; end
            if (GON_valid && GON_ready) nfire++;
        end
        check("drain_done_seen", int'(seen), 1);
        check("drain_fire_count", nfire, (er + 1) * (ec + 1) * (w + 1));
        check("done_tag_x", int'(tag_X), 15);
        check("done_tag_y", int'(tag_Y), 7);
        @(posedge clk); #1;
        GON_valid = 1'b0; GON_ready = 1'b0;
        @(negedge clk);
        check("drain_busy_after", int'(busy), 0);
    endtask

    initial begin
        int cyc;
        ev_t e;
        rst = 1'b1; start_cfg = 1'b0; start_drain = 1'b0;
        cfg_rows = '0; cfg_cols = '0; words_per_pe = '0;
        GON_valid = 1'b0; GON_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_setx", int'(set_XID), 0);
        check("rst_sety", int'(set_YID), 0);
        check("rst_xdata", int'(XID_scan_in), 0);
        check("rst_ydata", int'(YID_scan_in), 0);
        check("rst_tagx", int'(tag_X), 15);
        check("rst_tagy", int'(tag_Y), 7);

        // ID scan with a simultaneous drain request and a second one mid-scan
        for (int k = 0; k < ROWS * COLS; k++) begin
            e.kind = K_X; e.val = (ROWS * COLS - 1 - k) % COLS;
            exp_q.push_back(e);
        end
        for (int k = 0; k < ROWS; k++) begin
            e.kind = K_Y; e.val = ROWS - 1 - k;
            exp_q.push_back(e);
        end
        e.kind = K_D; e.val = 0;
        exp_q.push_back(e);
        @(posedge clk); #1;
        start_cfg = 1'b1; start_drain = 1'b1;
        @(posedge clk); #1;
        start_cfg = 1'b0; start_drain = 1'b0;
        cyc = 1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) break;
            @(posedge clk); #1;
            cyc++;
            start_drain = (cyc == 5);
        end
        check("scan_done_cycle", cyc, 55);
        start_drain = 1'b0;
        @(negedge clk);
        check("scan_busy_falls", int'(busy), 0);
        repeat (3) @(negedge clk);
        check("scan_no_drain", int'(busy), 0);

        run_drain(1, 2, 0, 2);
        run_drain(1, 1, 3, 1);
        run_drain(0, 12, 0, 2);

        // reset mid-drain at tag (1,1)
        for (int y = 0; y <= 1; y++)
            for (int x = 0; x <= 2; x++)
                if (y * 3 + x < 4) begin
                    e.kind = K_T; e.val = y * 16 + x;
                    exp_q.push_back(e);
                end
        @(posedge clk); #1;
        cfg_rows = 3'd1; cfg_cols = 4'd2; words_per_pe = 8'd0;
        start_drain = 1'b1;
        @(posedge clk); #1;
        start_drain = 1'b0; GON_valid = 1'b1; GON_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 GON_valid = 1'b0; GON_ready = 1'b0;
        @(negedge clk);
        check("mid_tag", int'(tag_Y) * 16 + int'(tag_X), 17);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_tagx", int'(tag_X), 15);
        check("abort_tagy", int'(tag_Y), 7);
        check("abort_queue", exp_q.size(), 0);
        run_drain(1, 2, 0, 2);

        for (int n = 0; n < 6; n++)
            run_drain(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 3)), 0);

        repeat (3) @(posedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
